// File: rtl/ballot_sequencer_pkg.sv
// Shared encodings and helpers for the ballot sequencer: command opcodes, FSM states,
// the BCD digit limit and counter widths.
package ballot_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_VOTE   = 2'd1,
    OP_FINISH = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int CNT_W  = 8;
  localparam int STEP_W = 4;

  // Index of the final pulse of a command.
  function automatic logic [STEP_W-1:0] last_step(input op_e op, input int finish_pulses);
    case (op)
      OP_VOTE:   return STEP_W'(2);
      OP_FINISH: return STEP_W'(finish_pulses - 1);
      default:   return '0;
    endcase
  endfunction

  function automatic logic cmd_bad(input op_e op, input logic [3:0] d1, input logic [3:0] d2);
    return (op == OP_RSVD) || ((op == OP_VOTE) && ((d1 > BCD_MAX) || (d2 > BCD_MAX)));
  endfunction

endpackage

// File: rtl/ballot_sequencer_pulse_timer.sv
// Down-counter used for both the high and low phase of each pulse; flags its
// terminal cycle and also whether the following cycle will be terminal.
module ballot_sequencer_pulse_timer
  import ballot_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last,
  output logic         last_next
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);
  // Lets the owner register a flag that lines up with the terminal cycle.
  assign last_next = load ? (load_val == '0) : (cnt <= W'(1));

endmodule

// File: rtl/ballot_sequencer.sv
// Converts START/VOTE/FINISH commands into the voting FSM's start/valid/digit/
// finish/swap strobe protocol and counts confirmed votes per election.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   PULSE | strobe for the current step held high
//   GAP   | strobes low; digit for the next step already presented
module ballot_sequencer
  import ballot_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES  = 1,
  parameter int GAP_CYCLES    = 1,
  parameter int FINISH_PULSES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_dig1,
  input  logic [3:0] cmd_dig2,
  input  logic       cmd_swap,
  output logic [3:0] digit,
  output logic       valid,
  output logic       start,
  output logic       finish,
  output logic       swap,
  output logic       done,
  output logic       err,
  output logic [7:0] votes_sent
);

  localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_e              state, state_n;
  op_e                 op_q, op_n;
  op_e                 cmd_op_e;
  logic [STEP_W-1:0]   step, step_n;
  logic [3:0]          dig1_q, dig1_n, dig2_q, dig2_n;
  logic                t_load;
  logic [CNT_W-1:0]    t_val;
  logic                t_last, t_last_next;
  logic                reject;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);

  ballot_sequencer_pulse_timer #(.W(CNT_W)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (t_load),
    .load_val  (t_val),
    .last      (t_last),
    .last_next (t_last_next)
  );

  always_comb begin
    state_n = state;
    step_n  = step;
    op_n    = op_q;
    dig1_n  = dig1_q;
    dig2_n  = dig2_q;
    t_load  = 1'b0;
    t_val   = '0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad(cmd_op_e, cmd_dig1, cmd_dig2)) begin
            reject = 1'b1;
          end else begin
            state_n = PULSE;
            step_n  = '0;
            op_n    = cmd_op_e;
            dig1_n  = cmd_dig1;
            dig2_n  = cmd_dig2;
            t_load  = 1'b1;
            t_val   = P_LOAD;
          end
        end
      end
      PULSE: begin
        if (t_last) begin
          state_n = GAP;
          t_load  = 1'b1;
          t_val   = G_LOAD;
        end
      end
      GAP: begin
        if (t_last) begin
          if (step == last_step(op_q, FINISH_PULSES)) begin
            state_n = IDLE;
          end else begin
            state_n = PULSE;
            step_n  = step + 1'b1;
            t_load  = 1'b1;
            t_val   = P_LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      op_q       <= OP_START;
      dig1_q     <= '0;
      dig2_q     <= '0;
      digit      <= '0;
      valid      <= 1'b0;
      start      <= 1'b0;
      finish     <= 1'b0;
      swap       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      votes_sent <= '0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      op_q   <= op_n;
      dig1_q <= dig1_n;
      dig2_q <= dig2_n;
      valid  <= (state_n == PULSE) && (op_n != OP_FINISH);
      start  <= (state_n == PULSE) && (op_n == OP_START);
      finish <= (state_n == PULSE) && (op_n == OP_FINISH);
      done   <= (state_n == GAP) && t_last_next && (step_n == last_step(op_n, FINISH_PULSES));
      err    <= reject;
      // During the gap after the first pulse the second digit is already set up.
      if ((state_n != IDLE) && (op_n == OP_VOTE)) begin
        digit <= ((state_n == PULSE) && (step_n == '0)) ? dig1_n : dig2_n;
      end
      if ((state == IDLE) && (state_n == PULSE)) begin
        if (op_n == OP_START) begin
          swap       <= 1'b0;
          votes_sent <= '0;
        end else if (op_n == OP_VOTE) begin
          swap <= cmd_swap;
        end
      end
      if ((state != PULSE) && (state_n == PULSE) && (op_n == OP_VOTE) &&
          (step_n == STEP_W'(2)) && (votes_sent != 8'hFF)) begin
        votes_sent <= votes_sent + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ballot_sequencer.sv
// Bench for ballot_sequencer: two instances (P=G=1 and P=2,G=3) checked cycle by
// cycle against a timing model derived from command length arithmetic.
module tb_ballot_sequencer;

  localparam int F = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset     [2];
  logic       cmd_valid [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_dig1  [2];
  logic [3:0] cmd_dig2  [2];
  logic       cmd_swap  [2];
  wire        cmd_ready [2];
  wire  [3:0] digit     [2];
  wire        valid     [2];
  wire        start     [2];
  wire        finish    [2];
  wire        swap      [2];
  wire        done      [2];
  wire        err       [2];
  wire  [7:0] votes_sent[2];

  ballot_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(1), .FINISH_PULSES(F)) u_dut0 (
    .clock(clock), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_dig1(cmd_dig1[0]), .cmd_dig2(cmd_dig2[0]), .cmd_swap(cmd_swap[0]),
    .digit(digit[0]), .valid(valid[0]), .start(start[0]), .finish(finish[0]), .swap(swap[0]),
    .done(done[0]), .err(err[0]), .votes_sent(votes_sent[0]));

  ballot_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(3), .FINISH_PULSES(F)) u_dut1 (
    .clock(clock), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_dig1(cmd_dig1[1]), .cmd_dig2(cmd_dig2[1]), .cmd_swap(cmd_swap[1]),
    .digit(digit[1]), .valid(valid[1]), .start(start[1]), .finish(finish[1]), .swap(swap[1]),
    .done(done[1]), .err(err[1]), .votes_sent(votes_sent[1]));

  int tests = 0;
  int fails = 0;
  int np [2];
  int ng [2];
  int votes_m [2];
  logic swap_m [2];

  // Voting-FSM tally for instance 0: two digits then a confirm; 13=C1, 22=C2, rest Nulo.
  int cap_n, cap_d1, cap_d2, c1, c2, nulo;
  always @(posedge clock) begin
    if (reset[0] || (valid[0] && start[0])) begin
      cap_n = 0; c1 = 0; c2 = 0; nulo = 0;
    end else if (valid[0]) begin
      if (cap_n == 0) cap_d1 = int'(digit[0]);
      else if (cap_n == 1) cap_d2 = int'(digit[0]);
      cap_n++;
      if (cap_n == 3) begin
        cap_n = 0;
        if (cap_d1 * 10 + cap_d2 == 13) c1++;
        else if (cap_d1 * 10 + cap_d2 == 22) c2++;
        else nulo++;
      end
    end
  end

  // {ready, valid, start, finish, done, err, swap, votes[7:0], digit[3:0]}
  function automatic logic [18:0] expv(input int p, input int g, input logic [1:0] op,
                                       input logic [3:0] d1, input logic [3:0] d2,
                                       input int k, input int l, input bit bad,
                                       input int vb, input int va, input logic sw);
    int step, ph;
    logic hi, v;
    logic [7:0] vs;
    logic [3:0] dg;
    if (bad) return {1'b1, 5'b00001, sw, vb[7:0], 4'd0};
    if (k > l) return {1'b1, 5'b00000, sw, va[7:0], 4'd0};
    step = (k - 1) / (p + g);
    ph   = (k - 1) % (p + g);
    hi   = (ph < p);
    v    = hi && (op != 2'd2);
    vs   = ((op == 2'd1) && (k <= 2 * (p + g))) ? vb[7:0] : va[7:0];
    dg   = (v && op == 2'd1) ? ((step == 0) ? d1 : d2) : 4'd0;
    return {1'b0, v, hi && (op == 2'd0), hi && (op == 2'd2), (k == l), 1'b0, sw, vs, dg};
  endfunction

  task automatic run_cmd(input string name, input int u, input logic [1:0] op,
                         input logic [3:0] d1, input logic [3:0] d2, input logic sw);
    int w, l, vb, va;
    bit bad, chk;
    logic swn;
    logic [18:0] e, o;
    w = 0;
    while (!cmd_ready[u] && w < 50) begin
      @(posedge clock); #1; w++;
    end
    if (!cmd_ready[u]) begin
      tests++; fails++;
      $display("FAIL %s_ready_wait u=%0d got=0 exp=1", name, u);
      return;
    end
    bad = (op == 2'd3) || (op == 2'd1 && (d1 > 9 || d2 > 9));
    l   = bad ? 0 : ((op == 2'd0) ? 1 : (op == 2'd1) ? 3 : F) * (np[u] + ng[u]);
    vb  = votes_m[u];
    va  = vb;
    swn = swap_m[u];
    if (!bad && op == 2'd0) begin vb = 0; va = 0; swn = 1'b0; end
    if (!bad && op == 2'd1) begin va = (vb == 255) ? 255 : vb + 1; swn = sw; end
    cmd_valid[u] = 1'b1; cmd_op[u] = op; cmd_dig1[u] = d1; cmd_dig2[u] = d2; cmd_swap[u] = sw;
    @(posedge clock); #1;
    cmd_valid[u] = 1'b0;
    cmd_op[u]    = 2'($urandom_range(0, 3));
    cmd_dig1[u]  = 4'($urandom_range(0, 15));
    cmd_dig2[u]  = 4'($urandom_range(0, 15));
    cmd_swap[u]  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= l + 1; k++) begin
      e   = expv(np[u], ng[u], op, d1, d2, k, l, bad, vb, va, swn);
      chk = !bad && (op == 2'd1) && e[17];
      o   = {cmd_ready[u], valid[u], start[u], finish[u], done[u], err[u], swap[u],
             votes_sent[u], chk ? digit[u] : 4'd0};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s u=%0d k=%0d got=%h exp=%h", name, u, k, o, e);
      end
      if (k <= l) begin @(posedge clock); #1; end
    end
    votes_m[u] = va;
    swap_m[u]  = swn;
  endtask

  task automatic test_reset();
    logic [18:0] o;
    for (int u = 0; u < 2; u++) begin
      o = {cmd_ready[u], valid[u], start[u], finish[u], done[u], err[u], swap[u],
           votes_sent[u], digit[u]};
      tests++;
      if (o !== {1'b1, 18'd0}) begin
        fails++;
        $display("FAIL reset_state u=%0d got=%h exp=%h", u, o, {1'b1, 18'd0});
      end
    end
  endtask

  task automatic test_start();
    run_cmd("start", 0, 2'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_vote();
    run_cmd("vote_91", 0, 2'd1, 4'd9, 4'd1, 1'b0);
    tests++;
    if (nulo !== 1 || c1 !== 0) begin
      fails++;
      $display("FAIL vote_91_tally got nulo=%0d c1=%0d exp nulo=1 c1=0", nulo, c1);
    end
  endtask

  task automatic test_election();
    run_cmd("elec_start", 0, 2'd0, 4'd0, 4'd0, 1'b0);
    run_cmd("elec_51", 0, 2'd1, 4'd5, 4'd1, 1'b0);
    run_cmd("elec_13", 0, 2'd1, 4'd1, 4'd3, 1'b0);
    run_cmd("elec_22", 0, 2'd1, 4'd2, 4'd2, 1'b0);
    run_cmd("elec_13b", 0, 2'd1, 4'd1, 4'd3, 1'b0);
    run_cmd("elec_20", 0, 2'd1, 4'd2, 4'd0, 1'b0);
    run_cmd("elec_12", 0, 2'd1, 4'd1, 4'd2, 1'b0);
    tests++;
    if (votes_sent[0] !== 8'd6 || c1 !== 2 || c2 !== 1 || nulo !== 3) begin
      fails++;
      $display("FAIL election_tally got votes=%0d c1=%0d c2=%0d nulo=%0d exp 6 2 1 3",
               votes_sent[0], c1, c2, nulo);
    end
  endtask

  task automatic test_swap();
    run_cmd("swap_13", 0, 2'd1, 4'd1, 4'd3, 1'b1);
    run_cmd("swap_22", 0, 2'd1, 4'd2, 4'd2, 1'b1);
    run_cmd("swap_start", 0, 2'd0, 4'd0, 4'd0, 1'b1);
  endtask

  task automatic test_finish();
    run_cmd("finish_p2g3", 1, 2'd2, 4'd0, 4'd0, 1'b0);
    run_cmd("finish_p1g1", 0, 2'd2, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_reject();
    run_cmd("reject_1_12", 0, 2'd1, 4'd1, 4'd12, 1'b1);
    run_cmd("reject_10_0", 1, 2'd1, 4'd10, 4'd0, 1'b0);
    run_cmd("reject_rsvd", 0, 2'd3, 4'd1, 4'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [3:0] o;
    run_cmd("pre_mid_vote", 0, 2'd1, 4'd4, 4'd4, 1'b1);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'd1; cmd_dig1[0] = 4'd1; cmd_dig2[0] = 4'd3; cmd_swap[0] = 1'b1;
    @(posedge clock); #1;
    cmd_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset[0] = 1'b1;
    @(posedge clock); #1;
    o = {valid[0], start[0], finish[0], done[0]};
    tests++;
    if (o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_strobes got=%b exp=0000", o);
    end
    reset[0] = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (cmd_ready[0] !== 1'b1 || votes_sent[0] !== 8'd0 || swap[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_release got ready=%b votes=%0d swap=%b exp 1 0 0",
               cmd_ready[0], votes_sent[0], swap[0]);
    end
    votes_m[0] = 0;
    swap_m[0]  = 1'b0;
  endtask

  task automatic test_random();
    int r, u;
    logic [1:0] op;
    logic [3:0] d1, d2;
    for (int i = 0; i < 60; i++) begin
      u  = i % 2;
      r  = $urandom_range(0, 9);
      op = (r < 2) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      d1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      d2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_cmd("random", u, op, d1, d2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation();
    run_cmd("sat_start", 0, 2'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      run_cmd("sat_vote", 0, 2'd1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)));
    end
    tests++;
    if (votes_sent[0] !== 8'd255) begin
      fails++;
      $display("FAIL saturation got=%0d exp=255", votes_sent[0]);
    end
  endtask

  initial begin
    np[0] = 1; ng[0] = 1; np[1] = 2; ng[1] = 3;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; cmd_valid[u] = 1'b0; cmd_op[u] = 2'd0;
      cmd_dig1[u] = 4'd0; cmd_dig2[u] = 4'd0; cmd_swap[u] = 1'b0;
      votes_m[u] = 0; swap_m[u] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    test_reset();
    test_start();
    test_vote();
    test_election();
    test_swap();
    test_finish();
    test_reject();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
